fetch_datapath: RTL and testbench
=================================

FETCH_DATAPATH -- requirements
Module: fetch_datapath

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath/register width in bits (legal 8..64).
REQ-002 SHALL have parameter PC_RESET, default 0, PC value loaded on reset.
REQ-003 SHALL have parameter PC_INC, default 1, PC increment per fetch, modulo 2^WIDTH.
REQ-004 Clk  input  1  single clock; all state updates on rising edge.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 Run  input  1  start fetching from IDLE.
REQ-007 Continue  input  1  release from PAUSE to next fetch.
REQ-008 LD_PC_EXT  input  1  load PC from PC_EXT (jump).
REQ-009 PC_EXT  input  WIDTH  jump target.
REQ-010 MEM_RDATA  input  WIDTH  memory read data, valid when MEM_READY=1.
REQ-011 MEM_READY  input  1  memory read complete.
REQ-012 MEM_REQ  output  1  memory read request; address is MAR.
REQ-013 PC, MAR, MDR, IR  output  WIDTH each  architectural registers.
REQ-014 BUS  output  WIDTH  internal shared bus value.
REQ-015 BUSY  output  1  high in any state except IDLE and PAUSE.
REQ-016 FETCH_DONE  output  1  high in PAUSE.

Function
REQ-017 SHALL implement FSM states IDLE, F1, F2, F3, PAUSE.
REQ-018 IDLE: Run=1 -> F1 next edge; otherwise remain.
REQ-019 F1 (one cycle): BUS=PC; MAR<=BUS; PC<=PC+PC_INC (wraps); -> F2.
REQ-020 F2: MEM_REQ=1; MDR<=MEM_RDATA and -> F3 on the edge where MEM_READY=1; otherwise hold, unbounded wait.
REQ-021 F3 (one cycle): BUS=MDR; IR<=BUS; -> PAUSE.
REQ-022 PAUSE: Continue=1 -> F1; otherwise remain; Run ignored.
REQ-023 BUS SHALL be all-zero outside F1/F3; exactly one source gated at a time, no tri-state.
REQ-024 LD_PC_EXT=1 SHALL load PC<=PC_EXT only in IDLE or PAUSE; ignored in F1-F3.
REQ-025 LD_PC_EXT and Continue together in PAUSE: PC_EXT loads this edge, F1 uses it next cycle.
REQ-026 Minimum fetch latency: Run/Continue edge to FETCH_DONE = 4 cycles with MEM_READY held high.
REQ-027 MEM_READY outside F2 SHALL be ignored; MDR unchanged.
REQ-028 MAR, MDR, IR SHALL change only in F1, F2 (on ready), F3 respectively.

Reset
REQ-029 Reset=0 SHALL immediately force IDLE, PC=PC_RESET, MAR=MDR=IR=0, MEM_REQ=0, BUSY=0, FETCH_DONE=0.
REQ-030 Reset asserted mid-fetch (any of F1-F3) SHALL abandon the fetch; no partial register update after deassertion.
REQ-031 After deassertion SHALL remain IDLE until Run=1.

Structure
REQ-032 Shared package fetch_pkg SHALL hold the FSM state enum and bus-select enum.
REQ-033 SHALL instantiate sub-module reg_n (parametrised WIDTH load register, async active-low reset, reset-value parameter) for PC, MAR, MDR, IR.
REQ-034 Incrementer and bus mux SHALL be inline combinational logic.

Verification
REQ-035 Reset, Run=1 one cycle, MEM_READY=1, MEM_RDATA=16'h1234 -> after 4 cycles MAR=0, MDR=IR=16'h1234, PC=1, FETCH_DONE=1.
REQ-036 MEM_READY held low 3 cycles in F2 -> MEM_REQ=1 for 4 cycles, MDR unchanged until ready edge, FETCH_DONE 3 cycles later than REQ-035.
REQ-037 PAUSE, LD_PC_EXT=1, PC_EXT=16'hFFFF, Continue=1 -> next F1 MAR=16'hFFFF, PC wraps to 0.
REQ-038 LD_PC_EXT=1, PC_EXT=16'h0040 during F2 -> PC unchanged (still PC+1).
REQ-039 Reset pulsed low during F2 -> IDLE immediately, all registers at reset values, MEM_REQ=0, no fetch without new Run.
REQ-040 WIDTH=32, PC_RESET=32'h1000, PC_INC=4 -> first fetch MAR=32'h1000, PC=32'h1004; BUS=0 in F2 and PAUSE.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch datapath.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package fetch_pkg;

    // Fetch sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_F1    = 3'd1,
        ST_F2    = 3'd2,
        ST_F3    = 3'd3,
        ST_PAUSE = 3'd4
    } state_t;

    // Which register drives the internal bus; BUS_NONE drives zero
    typedef enum logic [1:0] {
        BUS_NONE = 2'd0,
        BUS_PC   = 2'd1,
        BUS_MDR  = 2'd2
    } bus_sel_t;

endpackage

// File: rtl/reg_n.sv
// Generic WIDTH-bit load-enabled register with async active-low reset.
// Latency: 1 cycle from ld to q.
// Backpressure: none; loads unconditionally when ld is high.
//
// Ports: clk, rst_n, ld (load enable), d (next value), q (current value).
module reg_n #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_datapath.sv
// Instruction fetch datapath: PC -> MAR, memory read -> MDR, MDR -> IR, then pause.
// Latency: 4 cycles from run/cont edge to fetch_done with mem_ready held high.
// Backpressure: waits in F2 indefinitely until mem_ready; holds in PAUSE until cont.
//
// Ports: clk, rst_n; run (start from IDLE), cont (resume from PAUSE),
// ld_pc_ext/pc_ext (jump, honoured only in IDLE/PAUSE); mem_req/mem_rdata/
// mem_ready (memory read, address = mar); pc, mar, mdr, ir (architectural
// registers); bus (internal shared bus); busy; fetch_done (high in PAUSE).
module fetch_datapath
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] PC_RESET = '0,
    parameter logic [WIDTH-1:0] PC_INC   = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             cont,
    input  logic             ld_pc_ext,
    input  logic [WIDTH-1:0] pc_ext,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] mar,
    output logic [WIDTH-1:0] mdr,
    output logic [WIDTH-1:0] ir,
    output logic [WIDTH-1:0] bus,
    output logic             busy,
    output logic             fetch_done
);

    state_t           state_q;
    state_t           state_d;
    bus_sel_t         bus_sel;
    logic             pc_ld;
    logic             mar_ld;
    logic             mdr_ld;
    logic             ir_ld;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bus_sel    = BUS_NONE;
        mar_ld     = 1'b0;
        mdr_ld     = 1'b0;
        ir_ld      = 1'b0;
        mem_req    = 1'b0;
        busy       = 1'b1;
        fetch_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (run) state_d = ST_F1;
            end
            ST_F1: begin
                bus_sel = BUS_PC;
                mar_ld  = 1'b1;
                state_d = ST_F2;
            end
            ST_F2: begin
                mem_req = 1'b1;
                // MDR captures only on the completing edge; mem_ready elsewhere is ignored
                if (mem_ready) begin
                    mdr_ld  = 1'b1;
                    state_d = ST_F3;
                end
            end
            ST_F3: begin
                bus_sel = BUS_MDR;
                ir_ld   = 1'b1;
                state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                busy       = 1'b0;
                fetch_done = 1'b1;
                if (cont) state_d = ST_F1;
            end
            default: begin
                busy    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Single-source bus mux; idle value is zero rather than a floating bus
    always_comb begin
        bus = '0;
        case (bus_sel)
            BUS_PC:  bus = pc;
            BUS_MDR: bus = mdr;
            default: bus = '0;
        endcase
    end

    // PC advances during F1; external jumps only while the sequencer is parked,
    // so a jump issued together with cont is the address the next F1 uses.
    assign pc_inc = pc + PC_INC;

    always_comb begin
        pc_ld = 1'b0;
        pc_d  = pc_inc;
        if (state_q == ST_F1) begin
            pc_ld = 1'b1;
        end else if ((state_q == ST_IDLE || state_q == ST_PAUSE) && ld_pc_ext) begin
            pc_ld = 1'b1;
            pc_d  = pc_ext;
        end
    end

    reg_n #(.WIDTH(WIDTH), .RESET_VAL(PC_RESET)) u_pc (
        .clk(clk), .rst_n(rst_n), .ld(pc_ld), .d(pc_d), .q(pc)
    );

    reg_n #(.WIDTH(WIDTH), .RESET_VAL('0)) u_mar (
        .clk(clk), .rst_n(rst_n), .ld(mar_ld), .d(bus), .q(mar)
    );

    reg_n #(.WIDTH(WIDTH), .RESET_VAL('0)) u_mdr (
        .clk(clk), .rst_n(rst_n), .ld(mdr_ld), .d(mem_rdata), .q(mdr)
    );

    reg_n #(.WIDTH(WIDTH), .RESET_VAL('0)) u_ir (
        .clk(clk), .rst_n(rst_n), .ld(ir_ld), .d(bus), .q(ir)
    );

endmodule

// File: tb/tb_fetch_datapath.sv
// Self-checking bench for fetch_datapath: scoreboard of completed fetches plus
// directed checks of bus gating, wait states, jumps, reset and a 32-bit build.
// Latency/backpressure: n/a.
module tb_fetch_datapath;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run, cont, ld_pc_ext, mem_ready;
    logic [15:0] pc_ext, mem_rdata;
    logic        mem_req, busy, fetch_done;
    logic [15:0] pc, mar, mdr, ir, bus;

    logic        b_rst_n, b_run, b_cont, b_ld_pc_ext, b_mem_ready;
    logic [31:0] b_pc_ext, b_mem_rdata;
    logic        b_mem_req, b_busy, b_fetch_done;
    logic [31:0] b_pc, b_mar, b_mdr, b_ir, b_bus;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [15:0] mar;
        logic [15:0] mdr;
        logic [15:0] ir;
        logic [15:0] pc;
        int          done_cyc;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fetch_datapath #(.WIDTH(16), .PC_RESET(16'h0000), .PC_INC(16'h0001)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .cont(cont),
        .ld_pc_ext(ld_pc_ext), .pc_ext(pc_ext),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_req(mem_req),
        .pc(pc), .mar(mar), .mdr(mdr), .ir(ir), .bus(bus),
        .busy(busy), .fetch_done(fetch_done)
    );

    fetch_datapath #(.WIDTH(32), .PC_RESET(32'h0000_1000), .PC_INC(32'h4)) dut32 (
        .clk(clk), .rst_n(b_rst_n), .run(b_run), .cont(b_cont),
        .ld_pc_ext(b_ld_pc_ext), .pc_ext(b_pc_ext),
        .mem_rdata(b_mem_rdata), .mem_ready(b_mem_ready), .mem_req(b_mem_req),
        .pc(b_pc), .mar(b_mar), .mdr(b_mdr), .ir(b_ir), .bus(b_bus),
        .busy(b_busy), .fetch_done(b_fetch_done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [15:0] m, input logic [15:0] d, input logic [15:0] i,
                        input logic [15:0] p, input int dc);
        exp_t e;
        e.mar = m; e.mdr = d; e.ir = i; e.pc = p; e.done_cyc = dc;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (!fetch_done && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (!fetch_done) begin
            checks++;
            errors++;
            $display("FAIL wait_done: fetch_done still %0b after %0d cycles, expected 1", fetch_done, bound);
        end
    endtask

    // Monitor: every rising fetch_done must match the oldest expected fetch
    logic fd_prev = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (fetch_done && !fd_prev) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: fetch_done at cycle %0d, expected none", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_mar", 64'(mar), 64'(e.mar));
                    chk("sb_mdr", 64'(mdr), 64'(e.mdr));
                    chk("sb_ir",  64'(ir),  64'(e.ir));
                    chk("sb_pc",  64'(pc),  64'(e.pc));
                    chk("sb_latency", 64'(cyc), 64'(e.done_cyc));
                end
            end
            fd_prev = fetch_done;
        end
    end

    initial begin
        rst_n = 1'b0; run = 1'b0; cont = 1'b0; ld_pc_ext = 1'b0;
        pc_ext = '0; mem_rdata = '0; mem_ready = 1'b0;
        b_rst_n = 1'b0; b_run = 1'b0; b_cont = 1'b0; b_ld_pc_ext = 1'b0;
        b_pc_ext = '0; b_mem_rdata = 32'hDEAD_BEEF; b_mem_ready = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_pc", 64'(pc), 64'h0);
        chk("rst_mar", 64'(mar), 64'h0);
        chk("rst_mdr", 64'(mdr), 64'h0);
        chk("rst_ir", 64'(ir), 64'h0);
        chk("rst_ctl", {61'b0, mem_req, busy, fetch_done}, 64'h0);
        chk("rst_bus", 64'(bus), 64'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_hold", 64'(busy), 64'h0);

        // Basic fetch, memory always ready
        mem_ready = 1'b1; mem_rdata = 16'h1234; run = 1'b1;
        push(16'h0000, 16'h1234, 16'h1234, 16'h0001, cyc + 4);
        @(negedge clk);
        run = 1'b0;
        chk("f1_busy", 64'(busy), 64'h1);
        @(negedge clk);
        chk("f2_mem_req", 64'(mem_req), 64'h1);
        chk("f2_bus", 64'(bus), 64'h0);
        wait_done(10);
        chk("pause_bus", 64'(bus), 64'h0);
        chk("pause_busy", 64'(busy), 64'h0);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        chk("pause_run_ignored", 64'(fetch_done), 64'h1);

        // Three wait states in F2; ready outside F2 must not disturb MDR
        mem_ready = 1'b0; mem_rdata = 16'hABCD; cont = 1'b1;
        push(16'h0001, 16'hABCD, 16'hABCD, 16'h0002, cyc + 7);
        @(negedge clk);
        cont = 1'b0;
        chk("f1_bus_pc", 64'(bus), 64'h0001);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("wait_mem_req", 64'(mem_req), 64'h1);
            chk("wait_mdr_hold", 64'(mdr), 64'h1234);
            @(negedge clk);
        end
        chk("wait_mem_req4", 64'(mem_req), 64'h1);
        mem_ready = 1'b1;
        @(negedge clk);
        chk("f3_mem_req", 64'(mem_req), 64'h0);
        chk("f3_bus_mdr", 64'(bus), 64'hABCD);
        mem_rdata = 16'h5555;
        wait_done(5);
        chk("mdr_ignore_late_ready", 64'(mdr), 64'hABCD);

        // Jump requested mid-fetch is ignored
        mem_rdata = 16'h1111; cont = 1'b1;
        push(16'h0002, 16'h1111, 16'h1111, 16'h0003, cyc + 4);
        @(negedge clk);
        cont = 1'b0;
        @(negedge clk);
        ld_pc_ext = 1'b1; pc_ext = 16'h0040;
        @(negedge clk);
        chk("jump_ignored_f2", 64'(pc), 64'h0003);
        ld_pc_ext = 1'b0;
        wait_done(5);
        chk("jump_ignored_pause", 64'(pc), 64'h0003);

        // Jump together with cont: F1 uses the target and PC wraps
        mem_rdata = 16'h2222; ld_pc_ext = 1'b1; pc_ext = 16'hFFFF; cont = 1'b1;
        push(16'hFFFF, 16'h2222, 16'h2222, 16'h0000, cyc + 4);
        @(negedge clk);
        ld_pc_ext = 1'b0; cont = 1'b0;
        chk("jump_pc", 64'(pc), 64'hFFFF);
        chk("jump_bus", 64'(bus), 64'hFFFF);
        wait_done(5);

        // Reset in the middle of F2 abandons the fetch
        ld_pc_ext = 1'b1; pc_ext = 16'h0100;
        @(negedge clk);
        ld_pc_ext = 1'b0;
        chk("pause_jump_pc", 64'(pc), 64'h0100);
        chk("pause_jump_stay", 64'(fetch_done), 64'h1);
        mem_ready = 1'b0; cont = 1'b1;
        @(negedge clk);
        cont = 1'b0;
        @(negedge clk);
        chk("pre_rst_mem_req", 64'(mem_req), 64'h1);
        chk("pre_rst_mar", 64'(mar), 64'h0100);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ctl", {61'b0, mem_req, busy, fetch_done}, 64'h0);
        chk("midrst_pc", 64'(pc), 64'h0);
        chk("midrst_regs", {16'h0, mar, mdr, ir}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_idle", {62'b0, busy, fetch_done}, 64'h0);
        chk("post_rst_mar", 64'(mar), 64'h0);

        // Jump from IDLE, then fetch from the target
        ld_pc_ext = 1'b1; pc_ext = 16'h0200;
        @(negedge clk);
        ld_pc_ext = 1'b0;
        chk("idle_jump_pc", 64'(pc), 64'h0200);
        chk("idle_jump_stay", 64'(busy), 64'h0);
        mem_rdata = 16'h3333; run = 1'b1;
        push(16'h0200, 16'h3333, 16'h3333, 16'h0201, cyc + 4);
        @(negedge clk);
        run = 1'b0;
        wait_done(10);

        // 32-bit build with non-default reset PC and stride
        chk("w32_rst_pc", 64'(b_pc), 64'h1000);
        b_rst_n = 1'b1;
        @(negedge clk);
        b_run = 1'b1;
        @(negedge clk);
        b_run = 1'b0;
        chk("w32_f1_bus", 64'(b_bus), 64'h1000);
        @(negedge clk);
        chk("w32_f2_bus", 64'(b_bus), 64'h0);
        chk("w32_mar", 64'(b_mar), 64'h1000);
        chk("w32_pc", 64'(b_pc), 64'h1004);
        chk("w32_mem_req", 64'(b_mem_req), 64'h1);
        begin
            int n = 0;
            while (!b_fetch_done && n < 10) begin
                @(negedge clk);
                n++;
            end
        end
        chk("w32_done", 64'(b_fetch_done), 64'h1);
        chk("w32_pause_bus", 64'(b_bus), 64'h0);
        chk("w32_ir", 64'(b_ir), 64'hDEAD_BEEF);

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
